// File: rtl/weight_fetch_sequencer_pkg.sv
// Shared types and constants for the weight fetch sequencer and its output buffer.
package weight_fetch_sequencer_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/weight_fetch_sequencer_fifo.sv
// Small synchronous FIFO buffering weights between the memory read port and the output stream.
module weight_sync_fifo
    import weight_fetch_sequencer_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 16,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; emptiness is tracked by count, so no reset needed here.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Issues Weight_Memory addresses 0..NUM_WEIGHTS-1 and re-times the 1-cycle read data into a valid/ready stream.
module weight_fetch_sequencer
    import weight_fetch_sequencer_pkg::*;
#(
    parameter int NUM_WEIGHTS = 784,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] local_addr,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [ADDR_WIDTH-1:0] w_index,
    output logic                  w_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHTS - 1);

    seq_state_t            state;
    logic                  inflight;
    logic                  pop;
    logic                  issue;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] head;
    logic [SUM_W-1:0]      credit_used;
    logic [SUM_W-1:0]      credit_limit;

    assign pop     = w_valid && w_ready;
    assign w_valid = (count != '0);
    assign w_data  = w_valid ? head : '0;
    assign w_last  = w_valid && (w_index == LAST_IDX);

    // A read is issued only if its data is guaranteed a FIFO slot when it returns next cycle.
    assign credit_used  = {1'b0, count} + SUM_W'(inflight);
    assign credit_limit = SUM_W'(FIFO_DEPTH) + SUM_W'(pop);
    assign issue        = (state == ST_FETCH) && (credit_used < credit_limit);

    weight_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (weight_in),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            local_addr <= '0;
            inflight   <= 1'b0;
            w_index    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (pop) w_index <= w_last ? '0 : w_index + ADDR_WIDTH'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_FETCH;
                        local_addr <= '0;
                        busy       <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // Address parks on the last index rather than running past it.
                    if (issue) begin
                        if (local_addr == LAST_IDX) state <= ST_DRAIN;
                        else                        local_addr <= local_addr + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (pop && w_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: a 784-weight instance driven by a stream model and a 1-weight instance driven by a vector table.
module tb_weight_fetch_sequencer;

    localparam int N = 784;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        start, w_ready;
    logic [31:0] local_addr, w_index;
    logic [15:0] weight_in, w_data;
    logic        w_valid, w_last, busy, done;

    logic        start_b, w_ready_b;
    logic [31:0] local_addr_b, w_index_b;
    logic [15:0] weight_in_b, w_data_b;
    logic        w_valid_b, w_last_b, busy_b, done_b;

    weight_fetch_sequencer #(.NUM_WEIGHTS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .local_addr(local_addr), .weight_in(weight_in),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_index(w_index),
        .w_last(w_last), .busy(busy), .done(done)
    );

    weight_fetch_sequencer #(.NUM_WEIGHTS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_b), .local_addr(local_addr_b), .weight_in(weight_in_b),
        .w_valid(w_valid_b), .w_ready(w_ready_b), .w_data(w_data_b), .w_index(w_index_b),
        .w_last(w_last_b), .busy(busy_b), .done(done_b)
    );

    // Weight_Memory model: mem[i] = i, one-cycle registered read.
    always_ff @(posedge clk) begin
        weight_in   <= local_addr[15:0];
        weight_in_b <= local_addr_b[15:0];
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        valid;
        logic [15:0] data;
        logic        last;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [17];

    // One complete run on the 784-weight instance, checked against the ordered sequence 0..N-1.
    // mode 0: w_ready always 1; mode 1: w_ready random 50%.
    task automatic run_stream(input int mode, input int stall_val, input int mid_start,
                              input bit do_start, input bit start_on_done);
        int beats = 0;
        int cyc;
        int stall_left = 0;
        bit stall_done = 0;
        bit mid_done = 0;
        bit seen = 0;
        bit prev_stall = 0;
        logic [15:0] prev_data = '0;
        if (do_start) begin
            start = 1'b1;
            step();
        end
        start = 1'b0;
        cyc = 1;
        while (beats < N && cyc < 20 * N) begin
            start = 1'b0;
            if (mid_start >= 0 && !mid_done && beats == mid_start) begin
                start    = 1'b1;
                mid_done = 1'b1;
            end
            w_ready = (mode == 0) ? 1'b1 : 1'($urandom % 2);
            if (stall_val >= 0 && !stall_done && w_valid && w_data == 16'(stall_val)) begin
                stall_left = 20;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                w_ready = 1'b0;
                chk("stall_hold", w_data, 64'(stall_val));
                chk("stall_addr_bound", 64'(local_addr <= 32'(stall_val + 2)), 1);
                stall_left--;
            end
            if (cyc == 1) chk("first_addr", local_addr, 0);
            chk("busy_in_run", busy, 1);
            chk("addr_range", 64'(local_addr <= 32'(N - 1)), 1);
            chk("fifo_bound", 64'(dut.u_fifo.count <= 2), 1);
            if (!seen && w_valid) begin
                chk("latency", 64'(cyc), 3);
                seen = 1'b1;
            end
            if (mode == 0 && seen) chk("no_bubble", w_valid, 1);
            if (prev_stall) begin
                chk("stable_valid", w_valid, 1);
                chk("stable_data", w_data, prev_data);
            end
            if (w_valid && w_ready) begin
                chk("beat_data", w_data, 64'(beats));
                chk("beat_index", w_index, 64'(beats));
                chk("beat_last", w_last, 64'(beats == N - 1));
                beats++;
            end
            prev_stall = w_valid && !w_ready;
            prev_data  = w_data;
            step();
            cyc++;
        end
        chk("run_beats", 64'(beats), 64'(N));
        w_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        chk("valid_after_run", w_valid, 0);
        if (start_on_done) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end else begin
            step();
            chk("done_single", done, 0);
            for (int i = 0; i < 3; i++) begin
                chk("idle_valid", w_valid, 0);
                chk("idle_busy", busy, 0);
                step();
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        w_ready   = 1'b0;
        start_b   = 1'b0;
        w_ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", local_addr, 0);
        chk("rst_valid", w_valid, 0);
        chk("rst_data", w_data, 0);
        chk("rst_index", w_index, 0);
        chk("rst_last", w_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        step();

        // NUM_WEIGHTS=1 instance: plain run, backpressured run with ignored start, start in done cycle.
        //            start ready valid data  last busy done
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 17; i++) begin
            start_b   = tbl[i].start;
            w_ready_b = tbl[i].ready;
            chk($sformatf("n1_row%0d_valid", i), w_valid_b, tbl[i].valid);
            chk($sformatf("n1_row%0d_data", i), w_data_b, tbl[i].data);
            chk($sformatf("n1_row%0d_last", i), w_last_b, tbl[i].last);
            chk($sformatf("n1_row%0d_busy", i), busy_b, tbl[i].busy);
            chk($sformatf("n1_row%0d_done", i), done_b, tbl[i].done);
            step();
        end
        start_b   = 1'b0;
        w_ready_b = 1'b0;

        run_stream(0, -1, -1, 1'b1, 1'b0);
        run_stream(1, -1, -1, 1'b1, 1'b0);
        run_stream(0, 5, -1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run.
        begin
            int k = 0;
            start   = 1'b1;
            w_ready = 1'b1;
            step();
            start = 1'b0;
            while (!(w_valid && w_data == 16'd300) && k < 2000) begin
                step();
                k++;
            end
            chk("reach_beat300", w_data, 300);
            #2 rst = 1'b1;
            #1;
            chk("arst_addr", local_addr, 0);
            chk("arst_valid", w_valid, 0);
            chk("arst_data", w_data, 0);
            chk("arst_index", w_index, 0);
            chk("arst_last", w_last, 0);
            chk("arst_busy", busy, 0);
            chk("arst_done", done, 0);
            step();
            rst     = 1'b0;
            w_ready = 1'b0;
            step();
            chk("post_rst_valid", w_valid, 0);
            chk("post_rst_done", done, 0);
        end
        run_stream(0, -1, -1, 1'b1, 1'b0);

        run_stream(1, -1, 200, 1'b1, 1'b1);
        run_stream(0, -1, -1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
